// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter.
// Each grant lasts up to a per-port budget in cycles. The budget is the port's
// weight, or TIMEOUT when the weight is zero. A grant ends early if the owner
// drops its request. Exactly one idle cycle separates consecutive grants, and
// the search for the next owner starts just above the port released last.
module arbiter_wrr #(
  parameter  int NUM_PORTS = 4,
  parameter  int TIMEOUT   = 16,
  parameter  int WEIGHT_W  = 4,
  localparam int ID_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int TO_W      = $clog2(TIMEOUT + 1),
  localparam int CNT_W     = (WEIGHT_W > TO_W) ? WEIGHT_W : TO_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          request,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [ID_W-1:0]               grant_id,
  output logic                          active,
  output logic                          expire
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 active_q, active_d;
  logic                 expire_q, expire_d;

  logic                 sel_found;
  logic [ID_W-1:0]      sel_id;
  logic [WEIGHT_W-1:0]  sel_weight;

  // Pick the first requester at or above ptr, wrapping around to port 0.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    sel_found  = 1'b0;
    sel_id     = '0;
    sel_weight = '0;
    // The upper segment (ptr..N-1) is searched first, then the wrapped one (0..ptr-1).
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!sel_found && request[j] && (j >= int'(ptr_q))) begin
        sel_found  = 1'b1;
        sel_id     = ID_W'(j);
        sel_weight = weight[j*WEIGHT_W +: WEIGHT_W];
      end
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!sel_found && request[j] && (j < int'(ptr_q))) begin
        sel_found  = 1'b1;
        sel_id     = ID_W'(j);
        sel_weight = weight[j*WEIGHT_W +: WEIGHT_W];
      end
    end
  end

  // Next-state logic: issue a grant in IDLE, then count down the budget in GRANT.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    id_d     = id_q;
    active_d = active_q;
    expire_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d  = S_GRANT;
          grant_d  = NUM_PORTS'(1) << sel_id;
          id_d     = sel_id;
          active_d = 1'b1;
          // The weight is captured only here; later changes to it are ignored.
          cnt_d    = (sel_weight != '0) ? (CNT_W'(sel_weight) - CNT_W'(1))
                                        : CNT_W'(TIMEOUT - 1);
        end
      end
      S_GRANT: begin
        if (!request[id_q] || (cnt_q == '0)) begin
          // A dropped request takes priority over budget exhaustion: no expire.
          expire_d = request[id_q];
          state_d  = S_IDLE;
          grant_d  = '0;
          active_d = 1'b0;
          cnt_d    = '0;
          ptr_d    = (int'(id_q) == NUM_PORTS - 1) ? '0 : (id_q + ID_W'(1));
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      id_q     <= '0;
      active_q <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      id_q     <= id_d;
      active_q <= active_d;
      expire_q <= expire_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = id_q;
  assign active   = active_q;
  assign expire   = expire_q;

endmodule

// File: tb/tb_arbiter_wrr.sv
// Directed bench for arbiter_wrr (NUM_PORTS=3, TIMEOUT=5, WEIGHT_W=4).
// The expected outputs for each cycle are queued when the stimulus is applied.
// They are popped and compared one time unit after the following rising edge.
module tb_arbiter_wrr;

  localparam int N  = 3;
  localparam int TO = 5;
  localparam int WW = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    request;
  logic [N*WW-1:0] weight;
  logic [N-1:0]    grant;
  logic [1:0]      grant_id;
  logic            active;
  logic            expire;

  typedef struct {
    logic [N-1:0] g;
    logic [1:0]   id;
    logic         a;
    logic         e;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  arbiter_wrr #(.NUM_PORTS(N), .TIMEOUT(TO), .WEIGHT_W(WW)) dut (
    .clk      (clk),
    .rst      (rst),
    .request  (request),
    .weight   (weight),
    .grant    (grant),
    .grant_id (grant_id),
    .active   (active),
    .expire   (expire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence below never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected summary before time limit");
    $fatal(1);
  end

  // Pop the oldest expectation and compare it against the DUT outputs.
  task automatic check();
    exp_t x;
    if (sb.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL scoreboard: observed empty queue, expected an entry");
      return;
    end
    x = sb.pop_front();
    n_cmp++;
    assert (grant === x.g) else begin
      n_mis++;
      $error("FAIL %s grant: observed %b expected %b", x.tag, grant, x.g);
    end
    n_cmp++;
    assert (grant_id === x.id) else begin
      n_mis++;
      $error("FAIL %s grant_id: observed %0d expected %0d", x.tag, grant_id, x.id);
    end
    n_cmp++;
    assert (active === x.a) else begin
      n_mis++;
      $error("FAIL %s active: observed %b expected %b", x.tag, active, x.a);
    end
    n_cmp++;
    assert (expire === x.e) else begin
      n_mis++;
      $error("FAIL %s expire: observed %b expected %b", x.tag, expire, x.e);
    end
  endtask

  // Queue the outputs expected after the next edge, take the edge, then compare.
  task automatic cyc(input logic [N-1:0] g, input logic [1:0] id,
                     input logic a, input logic e, input string tag);
    exp_t x;
    x.g = g; x.id = id; x.a = a; x.e = e; x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    rst     = 1'b0;
    request = 3'b111;
    weight  = '0;

    // Reset held for 10 cycles with every port requesting.
    repeat (10) cyc(3'b000, 2'd0, 1'b0, 1'b0, "reset");

    // The first arbitration after reset starts from port 0 (budget TIMEOUT).
    rst = 1'b1;
    cyc(3'b001, 2'd0, 1'b1, 1'b0, "rst_release");
    request = 3'b000;
    cyc(3'b000, 2'd0, 1'b0, 1'b0, "drop0");

    // Single requester, weight 0: 5 cycles, expire pulse, one gap, re-grant.
    request = 3'b010;
    repeat (5) cyc(3'b010, 2'd1, 1'b1, 1'b0, "single_grant");
    cyc(3'b000, 2'd1, 1'b0, 1'b1, "single_expire");
    cyc(3'b010, 2'd1, 1'b1, 1'b0, "single_regrant");

    // A reset pulse mid-grant returns ptr to 0 before the round-robin check.
    rst     = 1'b0;
    request = 3'b111;
    weight  = {4'd2, 4'd3, 4'd1};
    cyc(3'b000, 2'd0, 1'b0, 1'b0, "rst_pulse");
    rst = 1'b1;

    // Round-robin with weights port2..0 = 2,3,1.
    cyc(3'b001, 2'd0, 1'b1, 1'b0, "rr_p0");
    cyc(3'b000, 2'd0, 1'b0, 1'b1, "rr_p0_expire");
    repeat (3) cyc(3'b010, 2'd1, 1'b1, 1'b0, "rr_p1");
    cyc(3'b000, 2'd1, 1'b0, 1'b1, "rr_p1_expire");
    repeat (2) cyc(3'b100, 2'd2, 1'b1, 1'b0, "rr_p2");
    cyc(3'b000, 2'd2, 1'b0, 1'b1, "rr_p2_expire");
    cyc(3'b001, 2'd0, 1'b1, 1'b0, "rr_p0_again");
    cyc(3'b000, 2'd0, 1'b0, 1'b1, "rr_p0_again_expire");

    // Early drop: port 1 with weight 8 drops its request during grant cycle 3.
    request = 3'b010;
    weight  = {4'd2, 4'd8, 4'd1};
    repeat (3) cyc(3'b010, 2'd1, 1'b1, 1'b0, "drop_grant");
    request = 3'b000;
    cyc(3'b000, 2'd1, 1'b0, 1'b0, "drop_release");
    // ptr must now be 2: with every port requesting, port 2 wins.
    request = 3'b111;
    repeat (2) cyc(3'b100, 2'd2, 1'b1, 1'b0, "drop_ptr2");
    cyc(3'b000, 2'd2, 1'b0, 1'b1, "drop_ptr2_expire");

    // Weight change mid-grant: port 0 captures 4, later change to 1 is ignored.
    request = 3'b001;
    weight  = {4'd2, 4'd8, 4'd4};
    cyc(3'b001, 2'd0, 1'b1, 1'b0, "wchg_grant");
    weight  = {4'd2, 4'd8, 4'd1};
    repeat (3) cyc(3'b001, 2'd0, 1'b1, 1'b0, "wchg_hold");
    cyc(3'b000, 2'd0, 1'b0, 1'b1, "wchg_expire");

    // Reset mid-grant of port 2: revoked with no expire, then port 1 wins.
    request = 3'b100;
    weight  = {4'd2, 4'd1, 4'd4};
    cyc(3'b100, 2'd2, 1'b1, 1'b0, "rmid_grant");
    rst     = 1'b0;
    request = 3'b110;
    cyc(3'b000, 2'd0, 1'b0, 1'b0, "rmid_revoke");
    rst = 1'b1;
    cyc(3'b010, 2'd1, 1'b1, 1'b0, "rmid_next");

    // Budget 1 with the request dropped in that same cycle: counts as a drop.
    request = 3'b000;
    cyc(3'b000, 2'd1, 1'b0, 1'b0, "drop_at_zero");
    cyc(3'b000, 2'd1, 1'b0, 1'b0, "idle_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/arbiter_wrr.md
ARBITER_WRR -- requirements
Module: arbiter_wrr

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of requesters sharing the resource; legal range 1..32.
REQ-002 Parameter TIMEOUT, default 16: grant budget in cycles for a port whose weight is 0; legal range 1..255.
REQ-003 Parameter WEIGHT_W, default 4: width of each per-port weight field.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-006 request  input  NUM_PORTS  per-port request level; bit i = port i.
REQ-007 weight  input  NUM_PORTS*WEIGHT_W  per-port grant budget in cycles; port i at bits [i*WEIGHT_W +: WEIGHT_W].
REQ-008 grant  output  NUM_PORTS  registered one-hot grant; all-zero when no grant.
REQ-009 grant_id  output  max(1,clog2(NUM_PORTS))  registered binary index of the granted port; holds last value when grant is zero.
REQ-010 active  output  1  registered, equals OR of grant.
REQ-011 expire  output  1  registered one-cycle pulse marking a grant revoked by budget exhaustion.

Function
REQ-012 State machine SHALL have two states: IDLE and GRANT.
REQ-013 IDLE: if request is non-zero, SHALL select the first requesting port searching upward from pointer ptr with wrap (ptr, ptr+1, ..., N-1, 0, ..., ptr-1), then enter GRANT.
REQ-014 Latency: request sampled at edge t in IDLE -> grant bit set and active=1 after edge t (visible cycle t+1); no combinational path from request to grant.
REQ-015 On entering GRANT, the counter SHALL load budget-1, where budget = weight[id] if non-zero, else TIMEOUT; weight is sampled only at this point, and changes during the grant are ignored.
REQ-016 GRANT, each edge, in priority order:
- (a) request[id]=0 -> release, expire=0;
- (b) counter=0 -> release, expire=1;
- (c) otherwise decrement the counter and hold grant.
REQ-017 Release SHALL clear grant and active, set ptr = id+1 (N-1 wraps to 0), and return to IDLE; exactly one grant-free cycle SHALL separate consecutive grants.
REQ-018 A port holding its request SHALL therefore be granted for exactly budget consecutive cycles.
REQ-019 expire SHALL be high for exactly the one cycle following the release edge in case (b), and 0 otherwise.
REQ-020 Requests from non-granted ports during GRANT SHALL have no effect; a request drop and counter=0 in the same cycle SHALL count as (a).
REQ-021 At most one grant bit SHALL ever be set; grant_id SHALL always match the set bit.
REQ-022 NUM_PORTS=1: ptr stays 0; behaviour otherwise identical.
REQ-023 Counter width SHALL be max(WEIGHT_W, clog2(TIMEOUT+1)); no overflow or underflow is permitted.

Reset
REQ-024 While rst=0 at an edge: state=IDLE, grant=0, grant_id=0, active=0, expire=0, ptr=0, counter=0.
REQ-025 Reset asserted mid-grant SHALL revoke the grant at that edge with no expire pulse; the first arbitration after reset starts from port 0.

Verification (NUM_PORTS=3, TIMEOUT=5, WEIGHT_W=4)
REQ-026 Reset: rst=0 for 10 cycles with request=111 -> grant=000, active=0, expire=0 throughout; after release, first grant=001.
REQ-027 Single requester: weights 0, request=010 held -> grant=010 for 5 cycles, expire pulse, 1 gap cycle, grant=010 again (ptr wraps past 2 and 0, finding no other requesters).
REQ-028 Round-robin: weights {2,3,1} (port2..0 = 2,3,1), request=111 held -> grant 001 x1, gap, 010 x3, gap, 100 x2, gap, 001 ...; expire after every grant.
REQ-029 Early drop: port 1 granted with weight 8; request[1] dropped on cycle 3 of the grant -> grant clears next edge, expire=0, ptr=2.
REQ-030 Weight change mid-grant: weight[0] changed from 4 to 1 during the grant of port 0 -> grant still lasts 4 cycles.
REQ-031 Reset mid-grant: rst=0 during the grant of port 2 -> grant=000 at that edge, no expire pulse; with request=110 after reset, next grant=010.
